// File: rtl/stopwatch_core.sv
// Stopwatch core: synchronised tick/button inputs, 4-state control FSM and
// a six-digit BCD mm:ss.cc counter with a lap-freeze register.
module stopwatch_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_100Hz,
    input  logic        btn_start,
    input  logic        btn_lap,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_hold,
    output logic        overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    // Per-digit maximum, least significant digit in [3:0].
    localparam logic [23:0] DIGIT_MAX = 24'h595999;

    logic [2:0]  raw_in;
    logic [2:0]  events;
    logic [1:0]  live_reg;
    logic        tick_ev;
    logic        start_ev;
    logic        lap_ev;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [23:0] count_reg;
    logic [23:0] count_next;
    logic [23:0] lap_reg;
    logic [23:0] lap_next;
    logic        ovf_reg;
    logic        ovf_next;
    logic [23:0] count_inc;
    logic [6:0]  carry;
    logic        advance;

    assign raw_in = {btn_lap, btn_start, clk_100Hz};

    // live_reg[1] marks the point where the synchroniser outputs reflect real input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_reg <= 2'b00;
        end else begin
            live_reg <= {live_reg[0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;
            logic armed_reg;
            logic event_reg;

            // An input must be seen low once after reset before a rise counts.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                    armed_reg <= 1'b0;
                    event_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                    if (live_reg[1] && !sync2_reg) begin
                        armed_reg <= 1'b1;
                    end
                    event_reg <= live_reg[1] & armed_reg & sync2_reg & ~prev_reg;
                end
            end

            assign events[gi] = event_reg;
        end
    endgenerate

    assign tick_ev  = events[0];
    assign start_ev = events[1];
    assign lap_ev   = events[2];

    assign carry[0] = 1'b1;

    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            logic [3:0] digit;
            logic       wrap;

            assign digit                = count_reg[4*gi +: 4];
            assign wrap                 = (digit == DIGIT_MAX[4*gi +: 4]);
            assign carry[gi+1]          = carry[gi] & wrap;
            assign count_inc[4*gi +: 4] = carry[gi] ? (wrap ? 4'd0 : digit + 4'd1) : digit;
        end
    endgenerate

    assign advance = tick_ev && ((state_reg == ST_RUN) || (state_reg == ST_LAP));

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        lap_next   = lap_reg;
        ovf_next   = ovf_reg;

        if (advance) begin
            count_next = count_inc;
            if (carry[6]) begin
                ovf_next = 1'b1;
            end
        end

        // Start always wins over a coincident lap.
        case (state_reg)
            ST_IDLE: begin
                if (start_ev) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_ev) begin
                    state_next = ST_PAUSE;
                end else if (lap_ev) begin
                    state_next = ST_LAP;
                    lap_next   = count_reg;
                end
            end
            ST_PAUSE: begin
                if (start_ev) begin
                    state_next = ST_RUN;
                end else if (lap_ev) begin
                    state_next = ST_IDLE;
                    count_next = 24'h000000;
                    ovf_next   = 1'b0;
                end
            end
            ST_LAP: begin
                if (start_ev) begin
                    state_next = ST_PAUSE;
                end else if (lap_ev) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= 24'h000000;
            lap_reg   <= 24'h000000;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            lap_reg   <= lap_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign disp_bcd = (state_reg == ST_LAP) ? lap_reg : count_reg;
    assign running  = (state_reg == ST_RUN) || (state_reg == ST_LAP);
    assign lap_hold = (state_reg == ST_LAP);
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_stopwatch_core.sv
// Stopwatch core bench: directed scenarios plus random event sequences checked
// against a centisecond-integer reference model.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_100Hz = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_lap = 1'b0;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_hold;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    int m_cnt;
    int m_lap;
    int m_st;
    bit m_ovf;

    stopwatch_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_100Hz (clk_100Hz),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .disp_bcd  (disp_bcd),
        .running   (running),
        .lap_hold  (lap_hold),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(int cs);
        int mn, sc, c;
        mn = cs / 6000;
        sc = (cs / 100) % 60;
        c  = cs % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [23:0] exp_disp();
        return to_bcd((m_st == S_LAP) ? m_lap : m_cnt);
    endfunction

    function automatic bit exp_running();
        return (m_st == S_RUN) || (m_st == S_LAP);
    endfunction

    function automatic void model_reset();
        m_cnt = 0;
        m_lap = 0;
        m_st  = S_IDLE;
        m_ovf = 1'b0;
    endfunction

    // Reference behaviour for events that land in the same clock cycle.
    function automatic void model_step(bit s, bit l, bit t);
        bit adv;
        int nst;
        adv = t && (m_st == S_RUN || m_st == S_LAP);
        nst = m_st;
        case (m_st)
            S_IDLE:  if (s) nst = S_RUN;
            S_RUN:   if (s) nst = S_PAUSE; else if (l) begin nst = S_LAP; m_lap = m_cnt; end
            S_PAUSE: if (s) nst = S_RUN; else if (l) begin nst = S_IDLE; m_cnt = 0; m_ovf = 1'b0; end
            default: if (s) nst = S_PAUSE; else if (l) nst = S_RUN;
        endcase
        if (adv) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 360000) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end
        end
        m_st = nst;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn_start = 1'b0;
        btn_lap = 1'b0;
        clk_100Hz = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    // Raise the selected inputs together for 2 cycles, then let the result settle.
    task automatic apply(bit s, bit l, bit t);
        @(negedge clk);
        if (s) btn_start = 1'b1;
        if (l) btn_lap = 1'b1;
        if (t) clk_100Hz = 1'b1;
        repeat (2) @(negedge clk);
        btn_start = 1'b0;
        btn_lap = 1'b0;
        clk_100Hz = 1'b0;
        repeat (4) @(negedge clk);
        model_step(s, l, t);
    endtask

    task automatic ticks(int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            clk_100Hz = 1'b1;
            repeat (2) @(negedge clk);
            clk_100Hz = 1'b0;
            repeat (2) @(negedge clk);
            model_step(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic preload(logic [23:0] bcd, int cs);
        @(negedge clk);
        force dut.count_reg = bcd;
        @(negedge clk);
        release dut.count_reg;
        m_cnt = cs;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec += 4;
        if (disp_bcd !== 24'h0) begin $display("FAIL reset_disp got %h want 000000", disp_bcd); n_err++; end
        if (running !== 1'b0) begin $display("FAIL reset_running got %b want 0", running); n_err++; end
        if (lap_hold !== 1'b0) begin $display("FAIL reset_lap_hold got %b want 0", lap_hold); n_err++; end
        if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %b want 0", overflow); n_err++; end
        $display("txn reset disp=%h running=%b", disp_bcd, running);
        do_reset();
    endtask

    task automatic test_latency();
        @(negedge clk);
        btn_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) btn_start = 1'b0;
            if (k == 3) begin
                n_vec++;
                if (running !== 1'b0) begin $display("FAIL latency_early got running=%b want 0", running); n_err++; end
            end
            if (k == 4) begin
                n_vec++;
                if (running !== 1'b1) begin $display("FAIL latency_exact got running=%b want 1", running); n_err++; end
            end
        end
        model_step(1'b1, 1'b0, 1'b0);
        $display("txn latency running=%b", running);
    endtask

    task automatic test_count150();
        do_reset();
        apply(1'b1, 1'b0, 1'b0);
        ticks(150);
        n_vec += 3;
        if (disp_bcd !== 24'h000150) begin $display("FAIL count150_disp got %h want 000150", disp_bcd); n_err++; end
        if (disp_bcd !== to_bcd(m_cnt)) begin $display("FAIL count150_model got %h want %h", disp_bcd, to_bcd(m_cnt)); n_err++; end
        if (running !== 1'b1) begin $display("FAIL count150_running got %b want 1", running); n_err++; end
        $display("txn count150 disp=%h running=%b", disp_bcd, running);
    endtask

    task automatic test_lap();
        do_reset();
        apply(1'b1, 1'b0, 1'b0);
        ticks(37);
        apply(1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 2; j++) begin
            n_vec += 2;
            if (disp_bcd !== 24'h000037) begin $display("FAIL lap_frozen got %h want 000037", disp_bcd); n_err++; end
            if (lap_hold !== 1'b1) begin $display("FAIL lap_hold_on got %b want 1", lap_hold); n_err++; end
            $display("txn lap_hold step=%0d disp=%h", j, disp_bcd);
            ticks(10);
        end
        apply(1'b0, 1'b1, 1'b0);
        n_vec += 3;
        if (disp_bcd !== 24'h000057) begin $display("FAIL lap_resume got %h want 000057", disp_bcd); n_err++; end
        if (lap_hold !== 1'b0) begin $display("FAIL lap_hold_off got %b want 0", lap_hold); n_err++; end
        if (running !== 1'b1) begin $display("FAIL lap_running got %b want 1", running); n_err++; end
        $display("txn lap_release disp=%h", disp_bcd);
    endtask

    task automatic test_overflow();
        do_reset();
        apply(1'b1, 1'b0, 1'b0);
        preload(24'h595998, 359998);
        ticks(1);
        n_vec += 2;
        if (disp_bcd !== 24'h595999) begin $display("FAIL ovf_last got %h want 595999", disp_bcd); n_err++; end
        if (overflow !== 1'b0) begin $display("FAIL ovf_early got %b want 0", overflow); n_err++; end
        ticks(1);
        n_vec += 3;
        if (disp_bcd !== 24'h000000) begin $display("FAIL ovf_wrap got %h want 000000", disp_bcd); n_err++; end
        if (overflow !== 1'b1) begin $display("FAIL ovf_set got %b want 1", overflow); n_err++; end
        if (running !== 1'b1) begin $display("FAIL ovf_running got %b want 1", running); n_err++; end
        $display("txn overflow disp=%h ovf=%b", disp_bcd, overflow);
        apply(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (overflow !== 1'b1) begin $display("FAIL ovf_sticky got %b want 1", overflow); n_err++; end
        apply(1'b0, 1'b1, 1'b0);
        n_vec += 3;
        if (overflow !== 1'b0) begin $display("FAIL ovf_clear got %b want 0", overflow); n_err++; end
        if (running !== 1'b0) begin $display("FAIL ovf_idle got running=%b want 0", running); n_err++; end
        if (disp_bcd !== 24'h000000) begin $display("FAIL ovf_idle_disp got %h want 000000", disp_bcd); n_err++; end
        $display("txn clear disp=%h ovf=%b", disp_bcd, overflow);
    endtask

    task automatic test_start_lap_same();
        do_reset();
        apply(1'b1, 1'b0, 1'b0);
        ticks(5);
        apply(1'b1, 1'b1, 1'b0);
        ticks(3);
        n_vec += 3;
        if (running !== 1'b0) begin $display("FAIL same_running got %b want 0", running); n_err++; end
        if (lap_hold !== 1'b0) begin $display("FAIL same_lap_hold got %b want 0", lap_hold); n_err++; end
        if (disp_bcd !== 24'h000005) begin $display("FAIL same_frozen got %h want 000005", disp_bcd); n_err++; end
        $display("txn start_lap_same disp=%h", disp_bcd);
    endtask

    task automatic test_tick_start();
        do_reset();
        apply(1'b1, 1'b0, 1'b0);
        ticks(10);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1);
        n_vec += 2;
        if (disp_bcd !== 24'h000010) begin $display("FAIL tickstart_hold got %h want 000010", disp_bcd); n_err++; end
        if (running !== 1'b1) begin $display("FAIL tickstart_run got %b want 1", running); n_err++; end
        ticks(1);
        n_vec++;
        if (disp_bcd !== 24'h000011) begin $display("FAIL tickstart_next got %h want 000011", disp_bcd); n_err++; end
        $display("txn tick_start disp=%h", disp_bcd);
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(1'b1, 1'b0, 1'b0);
        preload(24'h012345, 8345);
        ticks(1);
        n_vec++;
        if (disp_bcd !== 24'h012346) begin $display("FAIL midrst_pre got %h want 012346", disp_bcd); n_err++; end
        @(negedge clk);
        btn_start = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec += 2;
        if (disp_bcd !== 24'h0) begin $display("FAIL midrst_disp got %h want 000000", disp_bcd); n_err++; end
        if (running !== 1'b0) begin $display("FAIL midrst_running got %b want 0", running); n_err++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        n_vec += 2;
        if (running !== 1'b0) begin $display("FAIL midrst_held got running=%b want 0", running); n_err++; end
        if (disp_bcd !== 24'h0) begin $display("FAIL midrst_residual got %h want 000000", disp_bcd); n_err++; end
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
        btn_start = 1'b1;
        repeat (2) @(negedge clk);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
        model_step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (running !== 1'b1) begin $display("FAIL midrst_rearm got running=%b want 1", running); n_err++; end
        $display("txn reset_mid running=%b", running);
    endtask

    task automatic test_random();
        bit s, l, t;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            t = ($urandom_range(0, 9) < 6);
            s = ($urandom_range(0, 5) == 0);
            l = ($urandom_range(0, 4) == 0);
            apply(s, l, t);
            n_vec += 4;
            if (disp_bcd !== exp_disp()) begin $display("FAIL rand_disp txn=%0d got %h want %h", i, disp_bcd, exp_disp()); n_err++; end
            if (running !== exp_running()) begin $display("FAIL rand_running txn=%0d got %b want %b", i, running, exp_running()); n_err++; end
            if (lap_hold !== (m_st == S_LAP)) begin $display("FAIL rand_lap_hold txn=%0d got %b want %b", i, lap_hold, m_st == S_LAP); n_err++; end
            if (overflow !== m_ovf) begin $display("FAIL rand_overflow txn=%0d got %b want %b", i, overflow, m_ovf); n_err++; end
            $display("txn rand %0d s=%0b l=%0b t=%0b disp=%h run=%b hold=%b", i, s, l, t, disp_bcd, running, lap_hold);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_count150();
        test_lap();
        test_overflow();
        test_start_lap_same();
        test_tick_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d vectors", n_vec);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 clk  in  1  100 MHz system clock; the only clock in the block.
REQ-002 rst_n  in  1  reset; asynchronous, active-low.
REQ-003 clk_100Hz  in  1  100 Hz square wave from the clock divider, sampled as data; each rising edge is one centisecond tick.
REQ-004 btn_start  in  1  debounced button level; each rising edge is a start/stop event.
REQ-005 btn_lap  in  1  debounced button level; each rising edge is a lap/clear event.
REQ-006 disp_bcd  out  24  displayed time {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4-bit BCD each, min_t in [23:20].
REQ-007 running  out  1  high while the count advances (RUN or LAP).
REQ-008 lap_hold  out  1  high while the display is frozen (LAP).
REQ-009 overflow  out  1  sticky flag; set on wrap past 59:59.99.

Function
REQ-010 Each of clk_100Hz, btn_start and btn_lap SHALL pass a 2-FF synchroniser followed by a registered rising-edge detector, giving one single-cycle event per input rising edge.
REQ-011 Latency from a sampled input rising edge to the resulting state/count change SHALL be a fixed 3 clk cycles and SHALL be identical for all three inputs.
REQ-012 A 1-cycle-wide high pulse on any input SHALL NOT be guaranteed to register; the minimum guaranteed width is 2 clk cycles.
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, LAP.
REQ-014 Transitions: IDLE+start->RUN; RUN+start->PAUSE; PAUSE+start->RUN; RUN+lap->LAP (capture the live count into the lap register); LAP+lap->RUN; LAP+start->PAUSE; PAUSE+lap->IDLE (clear the count to 00:00.00).
REQ-015 A lap event in IDLE SHALL be ignored; no other event/state pair SHALL change the state.
REQ-016 If start and lap events occur in the same cycle, start SHALL be taken and lap SHALL be discarded.
REQ-017 The count SHALL advance by one centisecond on a tick event whenever the current state is RUN or LAP, including on the cycle a start event leaves that state.
REQ-018 A tick in the same cycle as IDLE->RUN or PAUSE->RUN SHALL NOT be counted.
REQ-019 Digit ranges and carries: cs_u 0-9; cs_t 0-9; sec_u 0-9; sec_t 0-5; min_u 0-9; min_t 0-5.
REQ-020 Each digit SHALL carry into the next digit when it wraps to 0.
REQ-021 A tick at 59:59.99 SHALL wrap the count to 00:00.00, set overflow, and leave the state unchanged.
REQ-022 overflow SHALL clear only on entry to IDLE or on reset.
REQ-023 disp_bcd SHALL show the lap register in LAP and the live count in every other state, updated in the same cycle as the state or count change.
REQ-024 The count SHALL be held in IDLE and PAUSE.
REQ-025 The lap register SHALL be written only on the RUN->LAP transition.
REQ-026 No BCD digit SHALL ever hold a value outside its range.

Reset
REQ-027 Assertion of rst_n low SHALL asynchronously force: state IDLE; count and lap register 00:00.00; disp_bcd 24'h000000; running 0; lap_hold 0; overflow 0.
REQ-028 Assertion of rst_n low SHALL asynchronously clear all synchroniser and edge-detector flops to 0.
REQ-029 Reset asserted mid-count SHALL discard the count and lap register, with no residual event after release.
REQ-030 After rst_n release, an input already high SHALL NOT generate an event until it goes low and rises again.

Verification
REQ-031 Reset, start, then 150 ticks -> disp_bcd=24'h000150, running=1.
REQ-032 From 00:00.37 in RUN: lap, 20 ticks, lap -> displays 000037 and lap_hold=1 during the ticks, then 000057 and lap_hold=0.
REQ-033 Preload 59:59.98 in RUN, 2 ticks -> 595999, then 000000 with overflow=1; pause, then lap -> IDLE, 000000, overflow=0.
REQ-034 Start and lap edges in the same cycle while in RUN -> PAUSE, lap_hold=0, count frozen.
REQ-035 Tick edge coincident with start from PAUSE at 000010 -> count stays 000010 that cycle; next tick -> 000011.
REQ-036 rst_n pulsed low mid-run at 01:23.45 with btn_start held high -> all outputs zero; no start event until btn_start falls and rises again.
